// File: rtl/mem_access_ctrl.sv
// Load/store sequencer toward a RAM with a ready strobe and wait timeout; two-cycle minimum latency.
// Requests that arrive while busy are dropped, never queued; strobes stay up until ram_ready or timeout.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_req,
    input  logic        st_req,
    input  logic [15:0] addr,
    input  logic [15:0] st_data,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ready,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_re,
    output logic        ram_we,
    output logic [15:0] ld_data,
    output logic        reg_in_sel,
    output logic        reg_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Counter value at which one more unanswered ACCESS cycle reaches TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic        op_st_q,    op_st_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic [15:0] ld_data_q,  ld_data_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q,      err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_st_q    <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            ld_data_q  <= 16'h0000;
            wait_cnt_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_st_q    <= op_st_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ld_data_q  <= ld_data_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_st_d    = op_st_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ld_data_d  = ld_data_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld_req || st_req) begin
                    state_d    = ST_ACCESS;
                    op_st_d    = st_req;  // store wins when both are raised
                    addr_d     = addr;
                    wdata_d    = st_data;
                    wait_cnt_d = 8'h00;
                end
            end
            ST_ACCESS: begin
                // Ready on the final allowed cycle still completes the access.
                if (ram_ready) begin
                    state_d    = ST_DONE;
                    wait_cnt_d = 8'h00;
                    if (!op_st_q) begin
                        ld_data_d = ram_rdata;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 8'h00;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'h01;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign ram_re     = (state_q == ST_ACCESS) && !op_st_q;
    assign ram_we     = (state_q == ST_ACCESS) &&  op_st_q;
    assign ld_data    = ld_data_q;
    assign reg_we     = (state_q == ST_DONE) && !op_st_q;
    assign reg_in_sel = (state_q == ST_DONE) && !op_st_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level reference model, directed scenarios and random traffic.
module tb_mem_access_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_req, st_req, ram_ready;
    logic [15:0] addr, st_data, ram_rdata;
    logic [15:0] ram_addr, ram_wdata, ld_data;
    logic        ram_re, ram_we, reg_in_sel, reg_we, busy, done, err;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_req     (ld_req),
        .st_req     (st_req),
        .addr       (addr),
        .st_data    (st_data),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ld_data    (ld_data),
        .reg_in_sel (reg_in_sel),
        .reg_we     (reg_we),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Reference model: one outstanding transaction, tracked as "in flight",
    // "completion pulse due" or "timeout pulse due".
    logic        m_acc, m_st, m_done, m_err;
    int          m_waited;
    logic [15:0] m_addr, m_wdata, m_ld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= 1'b0; m_st <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_waited <= 0; m_addr <= 16'h0; m_wdata <= 16'h0; m_ld <= 16'h0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_acc) begin
                if (ram_ready) begin
                    m_acc  <= 1'b0;
                    m_done <= 1'b1;
                    if (!m_st) m_ld <= ram_rdata;
                end else if (m_waited + 1 == TO) begin
                    m_acc <= 1'b0;
                    m_err <= 1'b1;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (!m_done && (ld_req || st_req)) begin
                m_acc    <= 1'b1;
                m_st     <= st_req;
                m_addr   <= addr;
                m_wdata  <= st_data;
                m_waited <= 0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int n_re = 0, n_we = 0, n_done = 0, n_err = 0, n_regwe = 0, n_sel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("busy",       32'(busy),       32'(m_acc | m_done));
        chk("ram_re",     32'(ram_re),     32'(m_acc & ~m_st));
        chk("ram_we",     32'(ram_we),     32'(m_acc & m_st));
        chk("done",       32'(done),       32'(m_done));
        chk("err",        32'(err),        32'(m_err));
        chk("reg_we",     32'(reg_we),     32'(m_done & ~m_st));
        chk("reg_in_sel", 32'(reg_in_sel), 32'(m_done & ~m_st));
        chk("ram_addr",   32'(ram_addr),   32'(m_addr));
        chk("ram_wdata",  32'(ram_wdata),  32'(m_wdata));
        chk("ld_data",    32'(ld_data),    32'(m_ld));
        if (ram_re)     n_re++;
        if (ram_we)     n_we++;
        if (done)       n_done++;
        if (err)        n_err++;
        if (reg_we)     n_regwe++;
        if (reg_in_sel) n_sel++;
    endtask

    // Compare at the falling edge, then return 1 time unit after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req = 1'b0; st_req = 1'b0; ram_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {25'd0, busy, ram_re, ram_we, done, err, reg_we, reg_in_sel}, 32'd0);
        chk({name, "_data"}, {ram_addr | ram_wdata, ld_data}, 32'd0);
    endtask

    int b_re, b_we, b_done, b_err, b_regwe, b_sel;
    task automatic snap();
        b_re = n_re; b_we = n_we; b_done = n_done; b_err = n_err; b_regwe = n_regwe; b_sel = n_sel;
    endtask

    int p_ready;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        addr = 16'h0; st_data = 16'h0; ram_rdata = 16'h0;
        #3;
        chk_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Load with ready on the first ACCESS cycle.
        snap();
        ld_req = 1'b1; addr = 16'h0012; st_data = 16'h7777;
        cyc();
        idle_inputs(); ram_ready = 1'b1; ram_rdata = 16'hBEEF;
        chk("ld_access_re", 32'(ram_re), 32'd1);
        chk("ld_access_addr", 32'(ram_addr), 32'h0012);
        cyc();
        ram_ready = 1'b0; ram_rdata = 16'h0000;
        chk("ld_done_pulse", {29'd0, done, reg_we, reg_in_sel}, 32'h7);
        chk("ld_data_beef", 32'(ld_data), 32'hBEEF);
        cyc();
        chk("ld_back_idle", {30'd0, busy, done}, 32'd0);
        cyc(); cyc();
        chk("ld_re_cycles", 32'(n_re - b_re), 32'd1);
        chk("ld_done_count", 32'(n_done - b_done), 32'd1);
        chk("ld_regwe_count", 32'(n_regwe - b_regwe), 32'd1);

        // Store with three wait cycles before ready.
        snap();
        st_req = 1'b1; addr = 16'h0100; st_data = 16'h1234;
        cyc();
        idle_inputs(); addr = 16'hFFFF; st_data = 16'hFFFF;
        repeat (3) cyc();
        ram_ready = 1'b1;
        chk("st_wdata", 32'(ram_wdata), 32'h1234);
        cyc();
        ram_ready = 1'b0;
        repeat (3) cyc();
        chk("st_we_cycles", 32'(n_we - b_we), 32'd4);
        chk("st_done_count", 32'(n_done - b_done), 32'd1);
        chk("st_no_regwe", 32'((n_regwe - b_regwe) + (n_sel - b_sel)), 32'd0);
        chk("st_addr_hold", 32'(ram_addr), 32'h0100);

        // Load and store together: only the store happens.
        snap();
        ld_req = 1'b1; st_req = 1'b1; addr = 16'h0055; st_data = 16'hAAAA;
        cyc();
        idle_inputs(); ram_ready = 1'b1; ram_rdata = 16'h1111;
        cyc();
        idle_inputs();
        repeat (3) cyc();
        chk("both_re_cycles", 32'(n_re - b_re), 32'd0);
        chk("both_we_cycles", 32'(n_we - b_we), 32'd1);
        chk("both_ld_kept", 32'(ld_data), 32'hBEEF);

        // Load that never sees ready times out.
        snap();
        ld_req = 1'b1; addr = 16'h0200;
        cyc();
        idle_inputs(); ram_rdata = 16'hDEAD;
        repeat (20) cyc();
        chk("to_re_cycles", 32'(n_re - b_re), 32'd15);
        chk("to_err_count", 32'(n_err - b_err), 32'd1);
        chk("to_no_done", 32'((n_done - b_done) + (n_regwe - b_regwe)), 32'd0);
        chk("to_ld_kept", 32'(ld_data), 32'hBEEF);
        chk("to_not_busy", 32'(busy), 32'd0);

        // Reset in the middle of ACCESS, then a clean load.
        ld_req = 1'b1; addr = 16'h0300;
        cyc();
        idle_inputs();
        cyc();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        cyc();
        rst_n = 1'b1;
        snap();
        ld_req = 1'b1; addr = 16'h0042;
        cyc();
        idle_inputs(); ram_ready = 1'b1; ram_rdata = 16'h5A5A;
        cyc();
        idle_inputs();
        repeat (2) cyc();
        chk("rst_ld_data", 32'(ld_data), 32'h5A5A);
        chk("rst_done_count", 32'(n_done - b_done), 32'd1);
        chk("rst_no_err", 32'(n_err - b_err), 32'd0);

        // Requests while busy are ignored.
        snap();
        ld_req = 1'b1; addr = 16'h0400;
        cyc();
        idle_inputs(); st_req = 1'b1; addr = 16'h0500;
        cyc();
        idle_inputs(); ld_req = 1'b1; addr = 16'h0600;
        cyc();
        idle_inputs(); ram_ready = 1'b1; ram_rdata = 16'hC0DE;
        cyc();
        idle_inputs();
        repeat (3) cyc();
        chk("busy_done_count", 32'(n_done - b_done), 32'd1);
        chk("busy_we_cycles", 32'(n_we - b_we), 32'd0);
        chk("busy_re_cycles", 32'(n_re - b_re), 32'd3);
        chk("busy_addr", 32'(ram_addr), 32'h0400);

        // Random traffic with varying RAM responsiveness and occasional resets.
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0:       p_ready = 50;
                1:       p_ready = 15;
                2:       p_ready = 0;
                default: p_ready = 90;
            endcase
            for (int i = 0; i < 400; i++) begin
                ld_req    = ($urandom_range(0, 3) == 0);
                st_req    = ($urandom_range(0, 3) == 0);
                addr      = 16'($urandom);
                st_data   = 16'($urandom);
                ram_rdata = 16'($urandom);
                ram_ready = ($urandom_range(0, 99) < p_ready);
                if ($urandom_range(0, 299) == 0) begin
                    #2 rst_n = 1'b0;
                    #1 chk_all_zero("rand_reset");
                    cyc();
                    rst_n = 1'b1;
                end else begin
                    cyc();
                end
            end
        end
        idle_inputs();
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
